// File: rtl/conv_pkg.sv
// Shared constants and FSM state type for the convolution scheduler and engine.
package conv_pkg;
    localparam int unsigned M  = 6;
    localparam int unsigned N  = 8;
    localparam int unsigned DW = 16;
    localparam int unsigned YW = 32;
    localparam int unsigned L  = M + N - 1;
    localparam int unsigned AW = $clog2((M > N) ? M : N);
    localparam int unsigned LW = $clog2(L);
    localparam int unsigned CW = $clog2(L + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        START,
        WAIT,
        DRAIN
    } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last one advanced past.
module rr_arbiter #(
    parameter int unsigned NREQ = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] gnt_onehot
);
    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] last;
    logic          found;

    // Search indices above the last grant first, then wrap to the low indices.
    always_comb begin
        gnt_onehot = '0;
        found      = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (PW'(i) > last)) begin
                gnt_onehot[i] = 1'b1;
                found         = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (PW'(i) <= last)) begin
                gnt_onehot[i] = 1'b1;
                found         = 1'b1;
            end
        end
    end

    // Reset points at the top index so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= PW'(NREQ - 1);
        end else if (advance) begin
            for (int i = 0; i < NREQ; i++) begin
                if (gnt_onehot[i]) last <= PW'(i);
            end
        end
    end
endmodule

// File: rtl/conv_sched.sv
// Scheduler for the shared convolution engine: arbitrate, load operands,
// start, watchdog the engine, then stream the results back to the requester.
module conv_sched
    import conv_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned TMO  = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    output logic            eng_ld_a,
    output logic            eng_ld_b,
    output logic [AW-1:0]   eng_addr,
    output logic [DW-1:0]   eng_wdata,
    output logic            eng_start,
    input  logic            eng_done,
    output logic [LW-1:0]   eng_rd_addr,
    input  logic [YW-1:0]   eng_rd_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [YW-1:0]   out_data,
    output logic            out_last,
    output logic            busy,
    output logic            err
);
    localparam int unsigned WW = $clog2(TMO + 1);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [WW-1:0]   wdog;
    logic [NREQ-1:0] arb_req;
    logic [NREQ-1:0] arb_gnt;
    logic            advance;
    logic            a_last;
    logic            b_last;
    logic            y_last;
    logic            expire;

    assign a_last  = (cnt == CW'(M - 1));
    assign b_last  = (cnt == CW'(N - 1));
    assign y_last  = (cnt == CW'(L - 1));
    // Done in the expiry cycle takes priority over the timeout.
    assign expire  = (state == WAIT) && !eng_done && (wdog == WW'(TMO - 1));
    assign advance = expire || ((state == DRAIN) && out_ready && y_last);
    // While a job runs the held grant is fed back so advance records its owner.
    assign arb_req = (state == IDLE) ? req : gnt;
    assign busy    = (state != IDLE);

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk        (clk),
        .rst        (rst),
        .req        (arb_req),
        .advance    (advance),
        .gnt_onehot (arb_gnt)
    );

    // wdog holds the number of cycles elapsed since the start pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            wdog  <= '0;
            gnt   <= '0;
            err   <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt   <= arb_gnt;
                        cnt   <= '0;
                        state <= LOAD_A;
                    end
                end
                LOAD_A: begin
                    if (in_valid) begin
                        if (a_last) begin
                            cnt   <= '0;
                            state <= LOAD_B;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                LOAD_B: begin
                    if (in_valid) begin
                        if (b_last) begin
                            cnt   <= '0;
                            state <= START;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                START: begin
                    wdog  <= WW'(1);
                    state <= WAIT;
                end
                WAIT: begin
                    if (eng_done) begin
                        cnt   <= '0;
                        state <= DRAIN;
                    end else if (expire) begin
                        err   <= 1'b1;
                        gnt   <= '0;
                        state <= IDLE;
                    end else begin
                        wdog <= wdog + WW'(1);
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (y_last) begin
                            gnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stream-side decode; everything is forced to zero outside its own state.
    always_comb begin
        in_ready    = 1'b0;
        eng_ld_a    = 1'b0;
        eng_ld_b    = 1'b0;
        eng_addr    = '0;
        eng_wdata   = '0;
        eng_start   = 1'b0;
        eng_rd_addr = '0;
        out_valid   = 1'b0;
        out_data    = '0;
        out_last    = 1'b0;
        case (state)
            LOAD_A: begin
                in_ready  = 1'b1;
                eng_ld_a  = in_valid;
                eng_addr  = AW'(cnt);
                eng_wdata = in_data;
            end
            LOAD_B: begin
                in_ready  = 1'b1;
                eng_ld_b  = in_valid;
                eng_addr  = AW'(cnt);
                eng_wdata = in_data;
            end
            START: eng_start = 1'b1;
            DRAIN: begin
                out_valid   = 1'b1;
                eng_rd_addr = LW'(cnt);
                out_data    = eng_rd_data;
                out_last    = y_last;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_conv_sched.sv
// Self-checking bench for conv_sched with a behavioural convolution engine attached.
module tb_conv_sched;
    import conv_pkg::*;

    localparam int unsigned NREQ = 2;
    localparam int unsigned TMO  = 1024;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] gnt;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [DW-1:0]   in_data = '0;
    logic            eng_ld_a, eng_ld_b;
    logic [AW-1:0]   eng_addr;
    logic [DW-1:0]   eng_wdata;
    logic            eng_start;
    logic            eng_done;
    logic [LW-1:0]   eng_rd_addr;
    logic [YW-1:0]   eng_rd_data;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [YW-1:0]   out_data;
    logic            out_last;
    logic            busy, err;

    always #5 clk = ~clk;

    conv_sched #(.NREQ(NREQ), .TMO(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .eng_ld_a(eng_ld_a), .eng_ld_b(eng_ld_b), .eng_addr(eng_addr),
        .eng_wdata(eng_wdata), .eng_start(eng_start), .eng_done(eng_done),
        .eng_rd_addr(eng_rd_addr), .eng_rd_data(eng_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .err(err)
    );

    // Engine stand-in: latches operands, convolves on start, pulses done after eng_lat cycles.
    logic [DW-1:0] ea [8];
    logic [DW-1:0] eb [8];
    logic [YW-1:0] ey [16];
    int            etim = 0;
    int            eng_lat = 3;
    bit            eng_en = 1'b1;
    logic          done_m = 1'b0;
    logic          done_force = 1'b0;

    assign eng_done    = done_m | done_force;
    assign eng_rd_data = ey[eng_rd_addr];

    function automatic logic [YW-1:0] eng_conv(input int k);
        longint s = 0;
        for (int j = 0; j < N; j++)
            if (k - j >= 0 && k - j < M)
                s += longint'($signed(ea[k - j])) * longint'($signed(eb[j]));
        return YW'(s);
    endfunction

    always @(posedge clk) begin
        if (eng_ld_a) ea[eng_addr] <= eng_wdata;
        if (eng_ld_b) eb[eng_addr] <= eng_wdata;
        done_m <= (etim == 1);
        if (eng_start && eng_en) begin
            for (int k = 0; k < L; k++) ey[k] <= eng_conv(k);
            etim <= eng_lat;
        end else if (etim != 0) begin
            etim <= etim - 1;
        end
    end

    int cyc = 0;
    int start_cnt = 0;
    int start_cyc = 0;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (eng_start) begin start_cnt++; start_cyc = cyc; end

    int n_chk = 0;
    int n_fail = 0;
    int last_g = NREQ - 1;
    logic [DW-1:0] ta [M];
    logic [DW-1:0] tbv [N];
    logic [YW-1:0] ty [L];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic fail_now(input string tag);
        n_chk++;
        n_fail++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    // Reference: Y[k] = sum over i of A[i]*B[k-i], wrapped to YW bits.
    function automatic void build_ref();
        for (int k = 0; k < L; k++) begin
            longint s = 0;
            for (int i = 0; i < M; i++)
                if (k - i >= 0 && k - i < N)
                    s += longint'($signed(ta[i])) * longint'($signed(tbv[k - i]));
            ty[k] = YW'(s);
        end
    endfunction

    function automatic int pick(input logic [NREQ-1:0] r);
        for (int k = 1; k <= NREQ; k++) begin
            int idx = (last_g + k) % NREQ;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic chk_rst(input string tag);
        chk({tag, "_gnt"}, gnt, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_ld_a"}, eng_ld_a, 0);
        chk({tag, "_ld_b"}, eng_ld_b, 0);
        chk({tag, "_addr"}, eng_addr, 0);
        chk({tag, "_wdata"}, eng_wdata, 0);
        chk({tag, "_start"}, eng_start, 0);
        chk({tag, "_rd_addr"}, eng_rd_addr, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; in_valid = 1'b0; in_data = 16'hbeef;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_rst("reset");
        rst = 1'b0;
        last_g = NREQ - 1;
    endtask

    // One job from grant to return-to-idle; called in an IDLE cycle just after a falling edge.
    task automatic do_job(input logic [NREQ-1:0] reqv, input bit ones, input int pct,
                          input int stall_at, input int abort_at, input bit no_done);
        int r, i, k, budget, s0, stalls;
        logic [NREQ-1:0] eg;
        r = pick(reqv);
        eg = '0;
        eg[r] = 1'b1;
        for (int j = 0; j < M; j++) ta[j] = ones ? DW'(1) : DW'($urandom);
        for (int j = 0; j < N; j++) tbv[j] = ones ? DW'(1) : DW'($urandom);
        build_ref();
        eng_en = !no_done;
        eng_lat = $urandom_range(6, 1);
        s0 = start_cnt;
        req = reqv;
        @(negedge clk);
        #1;
        chk("gnt", gnt, eg);
        chk("busy", busy, 1);
        i = 0;
        budget = 0;
        while (i < M + N) begin
            in_valid = ($urandom_range(99) < pct);
            in_data = (i < M) ? ta[i] : tbv[i - M];
            #1;
            chk("in_ready", in_ready, 1);
            if (in_valid) begin
                chk((i < M) ? "ld_a" : "ld_b", (i < M) ? eng_ld_a : eng_ld_b, 1);
                chk("eng_addr", eng_addr, (i < M) ? i : i - M);
                i++;
            end
            @(negedge clk);
            budget++;
            if (budget > 1000) begin fail_now("load"); in_valid = 1'b0; return; end
        end
        in_valid = 1'b0;
        #1;
        chk("eng_start", eng_start, 1);
        chk("in_ready_start", in_ready, 0);
        if (no_done) begin
            for (budget = 0; budget < TMO + 20; budget++) begin
                @(negedge clk);
                #1;
                if (err) break;
            end
            if (!err) begin
                fail_now("wdog");
            end else begin
                req = '0;
                chk("err_cycle", cyc - start_cyc, TMO);
                chk("gnt_wdog", gnt, 0);
                chk("busy_wdog", busy, 0);
                @(negedge clk);
                #1;
                chk("err_pulse", err, 0);
                last_g = r;
            end
            chk("start_count", start_cnt - s0, 1);
            return;
        end
        @(negedge clk);
        k = 0;
        stalls = 0;
        budget = 0;
        while (k < L) begin
            out_ready = !(out_valid && k == stall_at && stalls < 3);
            if (!out_ready) stalls++;
            in_valid = ($urandom_range(1) == 1);
            in_data = DW'($urandom);
            #1;
            chk("in_ready_idle", in_ready, 0);
            if (out_valid) begin
                chk($sformatf("y%0d", k), out_data, ty[k]);
                chk("out_last", out_last, k == L - 1);
                if (out_ready) k++;
            end
            @(negedge clk);
            if (abort_at >= 0 && k == abort_at) begin
                rst = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
                @(negedge clk);
                #1;
                chk_rst("rst_mid");
                rst = 1'b0;
                req = '0;
                last_g = NREQ - 1;
                return;
            end
            budget++;
            if (budget > 200) begin fail_now("drain"); in_valid = 1'b0; return; end
        end
        out_ready = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("gnt_end", gnt, 0);
        chk("busy_end", busy, 0);
        chk("start_count", start_cnt - s0, 1);
        last_g = r;
    endtask

    initial begin
        do_reset();
        // Stray engine done and operand valid while idle
        done_force = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        #1;
        chk("spur_in_ready", in_ready, 0);
        done_force = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("spur_busy", busy, 0);
        chk("spur_out_valid", out_valid, 0);

        do_job(2'b01, 1'b1, 100, -1, -1, 1'b0);
        req = '0;

        do_reset();
        do_job(2'b11, 1'b0, 100, -1, -1, 1'b0);
        do_job(2'b11, 1'b0, 100, -1, -1, 1'b0);
        req = '0;

        do_job(2'b01, 1'b0, 50, 5, -1, 1'b0);
        req = '0;

        do_job(2'b10, 1'b0, 100, -1, -1, 1'b1);
        req = '0;
        do_job(2'b01, 1'b0, 80, -1, -1, 1'b0);
        req = '0;

        do_job(2'b01, 1'b0, 100, -1, 4, 1'b0);
        do_job(2'b10, 1'b0, 70, -1, -1, 1'b0);
        req = '0;

        for (int n = 0; n < 4; n++) begin
            logic [NREQ-1:0] rv;
            rv = NREQ'($urandom_range(3, 1));
            do_job(rv, 1'b0, 60, (n == 1) ? 0 : 12, -1, 1'b0);
            req = '0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end
endmodule
